// File: rtl/addsub_rr_arbiter.sv
// Two-requester round-robin front end sharing one N-bit adder/subtractor.
// Grant in IDLE, compute in EXEC, hold the tagged result in RESP until taken.
module addsub_rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         prio;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         sub_q;
  logic         id_q;

  logic         grant;
  logic         winner;
  logic [N-1:0] bx;
  logic [N:0]   sum;
  logic         ovf;

  // Ready is gated by rst_n so that no grant is visible while reset is held.
  always_comb begin
    grant      = 1'b0;
    winner     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && state == IDLE) begin
      grant      = req0_valid | req1_valid;
      winner     = (req0_valid && req1_valid) ? prio : req1_valid;
      req0_ready = grant && !winner;
      req1_ready = grant && winner;
    end
  end

  always_comb begin
    bx  = sub_q ? ~b_q : b_q;
    sum = {1'b0, a_q} + {1'b0, bx} + {{N{1'b0}}, sub_q};
    ovf = (a_q[N-1] == bx[N-1]) && (sum[N-1] != a_q[N-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      id_q  <= 1'b0;
    end else if (state == IDLE && grant) begin
      a_q   <= winner ? req1_a   : req0_a;
      b_q   <= winner ? req1_b   : req0_b;
      sub_q <= winner ? req1_sub : req0_sub;
      id_q  <= winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= id_q;
          rsp_result <= sum[N-1:0];
          rsp_carry  <= sum[N];
          rsp_ovf    <= ovf;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio      <= ~rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed bench for addsub_rr_arbiter: vector table of single operations
// plus hand-written fairness, backpressure, reset and cancel sequences.
module tb_addsub_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [7:0] req0_a = '0;
  logic [7:0] req0_b = '0;
  logic       req0_sub = 1'b0;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [7:0] req1_a = '0;
  logic [7:0] req1_b = '0;
  logic       req1_sub = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_ovf;

  int checks = 0;
  int failures = 0;

  addsub_rr_arbiter #(.N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b0;
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_carry", rsp_carry, 0);
    check("rst_rsp_ovf", rsp_ovf, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    bit got;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_sub = v.sub;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_sub = v.sub;
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v.id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("op_grant", got, 1);
    check("op_loser_ready", v.id ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("op_exec_rsp_valid", rsp_valid, 0);
    check("op_exec_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    check("op_rsp_valid", rsp_valid, 1);
    check("op_rsp_id", rsp_id, v.id);
    check("op_rsp_result", rsp_result, v.res);
    check("op_rsp_carry", rsp_carry, v.carry);
    check("op_rsp_ovf", rsp_ovf, v.ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    vecs[0] = '{1'b0, 8'h42, 8'hC0, 1'b0, 8'h02, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'h32, 8'h9C, 1'b1, 8'h96, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};

    do_reset();
    foreach (vecs[i]) run_op(vecs[i]);

    // Fairness: both continuously valid, consumer always ready.
    do_reset();
    @(posedge clk); #1;
    req0_a = 8'h91; req0_b = 8'h64; req0_sub = 1'b0; req0_valid = 1'b1;
    req1_a = 8'hFF; req1_b = 8'hFF; req1_sub = 1'b0; req1_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("rr_ready0", req0_ready, (c % 6 == 0));
      check("rr_ready1", req1_ready, (c % 6 == 3));
      check("rr_rsp_valid", rsp_valid, (c % 3 == 2));
      if (c % 3 == 2) begin
        check("rr_rsp_id", rsp_id, (c % 6 == 5));
        check("rr_rsp_result", rsp_result, (c % 6 == 5) ? 8'hFE : 8'hF5);
        check("rr_rsp_carry", rsp_carry, (c % 6 == 5));
        check("rr_rsp_ovf", rsp_ovf, 0);
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: hold RESP for 10 cycles, then next grant goes to req1.
    do_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_a = 8'h42; req0_b = 8'hC0; req0_sub = 1'b0; req0_valid = 1'b1;
    req1_a = 8'h00; req1_b = 8'h01; req1_sub = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("bp_grant0", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("bp_exec_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_id", rsp_id, 0);
      check("bp_hold_result", rsp_result, 8'h02);
      check("bp_hold_flags", {rsp_carry, rsp_ovf}, 2'b10);
      check("bp_hold_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_cycle_valid", rsp_valid, 1);
    check("bp_release_cycle_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    check("bp_idle_valid", rsp_valid, 0);
    check("bp_next_grant", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Async reset mid-EXEC clears prio; mid-RESP drops rsp_valid at once.
    do_reset();
    run_op(vecs[0]);
    @(posedge clk); #1;
    req1_a = 8'h10; req1_b = 8'h20; req1_sub = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    check("ar_grant1", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("ar_exec_rsp_valid", rsp_valid, 0);
    check("ar_exec_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_after_grant0", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ar_resp_valid", rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_resp_drop", rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // req0 raised and dropped during RESP must never be granted.
    @(posedge clk); #1;
    req1_a = 8'h32; req1_b = 8'h9C; req1_sub = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("cx_grant1", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    req0_a = 8'h01; req0_b = 8'h01; req0_sub = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    check("cx_resp_valid", rsp_valid, 1);
    check("cx_resp_id", rsp_id, 1);
    check("cx_resp_result", rsp_result, 8'h96);
    seen0 = 0;
    if (req0_ready) seen0++;
    @(negedge clk);
    if (req0_ready) seen0++;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req0_ready) seen0++;
    end
    check("cx_req0_never_granted", seen0, 0);
    check("cx_final_valid", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
